// File: rtl/ram.sv
// Shared types and default widths for the RAM arbiter slice.
package ram;

    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_ADDR_W = 4;

    typedef enum logic {
        INIT,
        RUN
    } ram_arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } ram_arb_tag_t;

endpackage

// File: rtl/ram_rr_pick.sv
// Two-way round-robin picker: on a tie the client that was not granted last wins.
module ram_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                gnt_id = ~last;
                gnt    = last ? 2'b01 : 2'b10;
            end
            default: begin
                gnt    = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client RAM arbiter: clears the memory after reset, then issues one registered
// access per cycle with round-robin fairness and routes read data back by tag.
module ram_arbiter
    import ram::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DATA_W,
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_W,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              req_i,
    input  logic [1:0]              we_i,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    init_done_o,
    output logic                    ram_wr_en,
    output logic                    ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

    // Extra counter bit marks "sweep issued"; RUN starts once the last clear write has landed.
    localparam int unsigned CntW     = ADDR_WIDTH + 1;
    localparam int unsigned TagDepth = RD_LATENCY + 1;

    ram_arb_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;

    logic [1:0] pick_gnt;
    logic       pick_id;
    logic       grant;
    logic       sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    ram_arb_tag_t [TagDepth-1:0] tag_q, tag_d;

    ram_rr_pick u_pick (
        .req    (req_i),
        .last   (last_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    assign gnt_o     = (state_q == RUN) ? pick_gnt : 2'b00;
    assign grant     = |gnt_o;
    assign sel_we    = pick_id ? we_i[1] : we_i[0];
    assign sel_addr  = pick_id ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
    assign sel_wdata = pick_id ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            INIT: begin
                if (cnt_q[ADDR_WIDTH]) begin
                    state_d = RUN;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    wr_data_d = '0;
                    cnt_d     = cnt_q + CntW'(1);
                end
            end
            RUN: begin
                if (grant) begin
                    last_d = pick_id;
                    if (sel_we) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_wdata;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = sel_addr;
                    end
                end
            end
        endcase
    end

    // Stage 0 is the cycle the read sits on the RAM pins; the last stage lines up with rd_data.
    always_comb begin
        tag_d          = '0;
        tag_d[0].valid = grant & ~sel_we;
        tag_d[0].id    = pick_id;
        for (int i = 1; i < TagDepth; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            tag_q     <= tag_d;
        end
    end

    always_comb begin
        rvalid_o = 2'b00;
        if (tag_q[TagDepth-1].valid) begin
            rvalid_o[tag_q[TagDepth-1].id] = 1'b1;
        end
    end

    assign rdata_o     = ram_rd_data;
    assign init_done_o = (state_q == RUN);
    assign ram_wr_en   = wr_en_q;
    assign ram_rd_en   = rd_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural 1-cycle RAM, scenario tasks, read-return scoreboard.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [1:0] we_i = 2'b00;
    logic [7:0] addr_i = 8'h00;
    logic [15:0] wdata_i = 16'h0000;
    logic [1:0] gnt_o;
    logic [1:0] rvalid_o;
    logic [7:0] rdata_o;
    logic       init_done_o;
    logic       ram_wr_en;
    logic       ram_rd_en;
    logic [3:0] ram_wr_addr;
    logic [3:0] ram_rd_addr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;

    logic       preload = 1'b0;
    logic [7:0] mem [16];
    logic [7:0] model_mem [16];

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    ram_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .RD_LATENCY (1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .init_done_o (init_done_o),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write commits at the sampling edge; read data registered one cycle later.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
            ram_rd_data <= 8'h5A;
        end else begin
            if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
            if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        end
    end

    // Scoreboard: each rvalid pops the oldest expected read and checks id, data and timing.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_o !== 2'b00) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL rvalid_unexpected: got rvalid=%b data=%h want no rvalid",
                         rvalid_o, rdata_o);
            end else begin
                e = sb_q.pop_front();
                if (rvalid_o !== (2'b01 << e.id) || rdata_o !== e.data || cyc != e.due)
                    $display("FAIL rvalid_return: got rvalid=%b data=%h cyc=%0d want rvalid=%b data=%h cyc=%0d",
                             rvalid_o, rdata_o, cyc, 2'b01 << e.id, e.data, e.due);
                else
                    n_pass++;
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            n_checks++;
            e = sb_q.pop_front();
            $display("FAIL rvalid_missing: got rvalid=%b at cyc=%0d want id %0d data=%h",
                     rvalid_o, cyc, e.id, e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [7:0] d0, input logic [7:0] d1);
        req_i   = r;
        we_i    = w;
        addr_i  = {a1, a0};
        wdata_i = {d1, d0};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        preload = 1'b1;
        drive(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_o);
        else n_pass++;
        n_checks++;
        if ({rvalid_o, init_done_o} !== 3'b000)
            $display("FAIL reset_rvalid_done: got %b want 000", {rvalid_o, init_done_o});
        else n_pass++;
        n_checks++;
        if ({ram_wr_en, ram_rd_en} !== 2'b00)
            $display("FAIL reset_enables: got %b want 00", {ram_wr_en, ram_rd_en});
        else n_pass++;
        n_checks++;
        if ({ram_wr_addr, ram_rd_addr, ram_wr_data} !== 16'h0000)
            $display("FAIL reset_addr_data: got %h want 0000",
                     {ram_wr_addr, ram_rd_addr, ram_wr_data});
        else n_pass++;
        n_checks++;
        if (rdata_o !== 8'h5A) $display("FAIL reset_rdata_pass: got %h want 5a", rdata_o);
        else n_pass++;
    endtask

    // Entered near a negedge with rstn low; requests are held to show gnt stays 0.
    task automatic test_init_sweep();
        logic all_zero;
        drive(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== {1'b1, 4'(i), 8'h00})
                $display("FAIL sweep_write_%0d: got en=%b addr=%h data=%h want en=1 addr=%h data=00",
                         i, ram_wr_en, ram_wr_addr, ram_wr_data, 4'(i));
            else n_pass++;
            n_checks++;
            if ({gnt_o, init_done_o} !== 3'b000)
                $display("FAIL sweep_gnt_done_%0d: got gnt=%b done=%b want gnt=00 done=0",
                         i, gnt_o, init_done_o);
            else n_pass++;
        end
        drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({init_done_o, ram_wr_en, ram_rd_en} !== 3'b100)
            $display("FAIL sweep_end: got done=%b wr_en=%b rd_en=%b want done=1 wr_en=0 rd_en=0",
                     init_done_o, ram_wr_en, ram_rd_en);
        else n_pass++;
        all_zero = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (mem[i] !== 8'h00) all_zero = 1'b0;
            model_mem[i] = 8'h00;
        end
        n_checks++;
        if (all_zero !== 1'b1) $display("FAIL sweep_mem_clear: got nonzero word want all 00");
        else n_pass++;
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        drive(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b01) $display("FAIL wr_gnt: got %b want 01", gnt_o);
        else n_pass++;
        model_mem[3] = 8'hA5;
        @(posedge clk); #1;
        drive(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b01) $display("FAIL rd_gnt: got %b want 01", gnt_o);
        else n_pass++;
        n_checks++;
        if ({ram_wr_en, ram_rd_en, ram_wr_addr, ram_wr_data} !== {2'b10, 4'h3, 8'hA5})
            $display("FAIL wr_issue: got wr=%b rd=%b addr=%h data=%h want wr=1 rd=0 addr=3 data=a5",
                     ram_wr_en, ram_rd_en, ram_wr_addr, ram_wr_data);
        else n_pass++;
        sb_q.push_back('{id: 1'b0, data: model_mem[3], due: cyc + 2});
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data} !==
            {1'b1, 4'h3, 1'b0, 4'h3, 8'hA5})
            $display("FAIL rd_issue: got rd=%b raddr=%h wr=%b waddr=%h wdata=%h want rd=1 raddr=3 wr=0 waddr=3 wdata=a5",
                     ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_contention();
        logic exp_id;
        @(posedge clk); #1;
        drive(2'b01, 2'b01, 4'h1, 4'h0, 8'h11, 8'h00);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b01) $display("FAIL cont_wr0_gnt: got %b want 01", gnt_o);
        else n_pass++;
        model_mem[1] = 8'h11;
        @(posedge clk); #1;
        drive(2'b10, 2'b10, 4'h0, 4'h2, 8'h00, 8'h22);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b10) $display("FAIL cont_wr1_gnt: got %b want 10", gnt_o);
        else n_pass++;
        model_mem[2] = 8'h22;
        for (int k = 0; k < 6; k++) begin
            exp_id = k[0];
            @(posedge clk); #1;
            drive(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00);
            @(negedge clk);
            n_checks++;
            if (gnt_o !== (2'b01 << exp_id))
                $display("FAIL cont_gnt_%0d: got %b want %b", k, gnt_o, 2'b01 << exp_id);
            else n_pass++;
            sb_q.push_back('{id: exp_id, data: exp_id ? model_mem[2] : model_mem[1],
                             due: cyc + 2});
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drive(2'b10, 2'b10, 4'h0, 4'h7, 8'h00, 8'h3C);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b10) $display("FAIL b2b_wr_gnt: got %b want 10", gnt_o);
        else n_pass++;
        model_mem[7] = 8'h3C;
        @(posedge clk); #1;
        drive(2'b10, 2'b00, 4'h0, 4'h7, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b10) $display("FAIL b2b_rd_gnt: got %b want 10", gnt_o);
        else n_pass++;
        sb_q.push_back('{id: 1'b1, data: model_mem[7], due: cyc + 2});
        idle(3);
    endtask

    // Client 1 was granted last, so client 0 wins the first tie and client 1 the next cycle.
    task automatic test_starvation();
        logic [1:0] exp_g;
        logic       pend1;
        int         waited;
        pend1  = 1'b1;
        waited = 0;
        for (int k = 0; k < 5; k++) begin
            exp_g = (k == 1) ? 2'b10 : 2'b01;
            @(posedge clk); #1;
            drive({pend1, 1'b1}, 2'b00, 4'h3, 4'h7, 8'h00, 8'h00);
            @(negedge clk);
            n_checks++;
            if (gnt_o !== exp_g) $display("FAIL starve_gnt_%0d: got %b want %b", k, gnt_o, exp_g);
            else n_pass++;
            sb_q.push_back('{id: exp_g[1], data: exp_g[1] ? model_mem[7] : model_mem[3],
                             due: cyc + 2});
            if (pend1) begin
                if (gnt_o[1] === 1'b1) pend1 = 1'b0;
                else waited++;
            end
        end
        n_checks++;
        if (pend1 !== 1'b0 || waited > 2)
            $display("FAIL starve_bound: got pending=%b waited=%0d want pending=0 waited<=2",
                     pend1, waited);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        drive(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b01) $display("FAIL rst_rd_gnt: got %b want 01", gnt_o);
        else n_pass++;
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
        rstn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({rvalid_o, init_done_o, ram_rd_en} !== 4'b0000)
                $display("FAIL rst_quiet_%0d: got rvalid=%b done=%b rd_en=%b want all 0",
                         k, rvalid_o, init_done_o, ram_rd_en);
            else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
        test_init_sweep();
        test_write_read();
        idle(4);
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-client controller that shares the single-port-pair `ram_rtl` memory between requesters. It clears the whole memory after reset, then grants at most one access per cycle with round-robin fairness. It drives the RAM `wr_en/rd_en/wr_addr/rd_addr/wr_data` pins from registers and routes `rd_data` back to the client that issued the read. It sits between client logic and `ram_rtl` inside the RAM subsystem and is driven through `ram_intf`-style signals.

## Interface
Parameters:
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 4: RAM address width; depth = 2**ADDR_WIDTH.
- `RD_LATENCY`, 1: cycles from RAM sampling `rd_en` to `rd_data` valid.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rstn` input 1: reset, asynchronous assert, active-low.
- `req_i` input 2: per-client request; held with fields stable until granted.
- `we_i` input 2: per-client op, 1 = write, 0 = read.
- `addr_i` input 2×ADDR_WIDTH: per-client address.
- `wdata_i` input 2×DATA_WIDTH: per-client write data.
- `gnt_o` output 2: per-client accept, combinational, one-hot or zero.
- `rvalid_o` output 2: per-client read-data valid, one-cycle pulse.
- `rdata_o` output DATA_WIDTH: read data, shared, qualified by `rvalid_o`.
- `init_done_o` output 1: high once the clear sweep has finished.
- `ram_wr_en`, `ram_rd_en` output 1: to RAM.
- `ram_wr_addr`, `ram_rd_addr` output ADDR_WIDTH: to RAM.
- `ram_wr_data` output DATA_WIDTH: to RAM.
- `ram_rd_data` input DATA_WIDTH: from RAM.

## Operation
- **States:** `INIT` → `RUN`.
  - Reset enters `INIT` with sweep counter = 0.
- **INIT:**
  - Each cycle, write 0 to address = counter, then increment the counter.
  - After the write to address 2**ADDR_WIDTH−1, go to `RUN` and set `init_done_o`.
  - `gnt_o` is forced to 0 throughout `INIT`.
- **RUN, arbitration:**
  - Round-robin pointer `last` is reset to 1, so client 0 wins the first tie.
  - With a single request, that client is granted.
  - With both requesting, the client ≠ `last` is granted.
  - `last` updates to the granted client on every grant.
- **Issue:**
  - A grant in cycle T registers the op; at T+1 `ram_wr_en` or `ram_rd_en` is high for exactly one cycle with the captured address/data.
  - The unused port's enable is 0; its address/data hold their previous values.
- **Read return:**
  - A tag pipeline of depth 1+RD_LATENCY (valid bit + client id) tracks each read.
  - At T+1+RD_LATENCY, `rvalid_o[id]` pulses and `rdata_o` = `ram_rd_data`.
- **Ordering:**
  - Requests execute in grant order.
  - A read granted the cycle after a write to the same address returns the new data. This relies on the RAM write committing at the same edge it samples `wr_en`.
- No back-pressure on read return: clients must accept `rvalid_o`.

## Timing
- **Reset values:**
  - `gnt_o`=0, `rvalid_o`=0, `rdata_o` passes `ram_rd_data`, `init_done_o`=0.
  - `ram_wr_en`=0, `ram_rd_en`=0.
  - `ram_wr_addr`, `ram_rd_addr`, `ram_wr_data` = 0.
  - All tags cleared.
- **Init duration:** first sweep write appears the first cycle after `rstn` deasserts. `init_done_o` rises after 2**ADDR_WIDTH cycles (16 at default).
- **Throughput:** one grant per cycle in `RUN`, with no bubbles between back-to-back grants.
- **Read latency:** grant to `rvalid_o` is 1+RD_LATENCY cycles (2 at default). Write has no completion signal.
- **Reset mid-operation:** immediately returns to `INIT` with counter 0. In-flight tags are dropped and no `rvalid_o` is produced for them.
- **Idle request change:** a `req_i` deasserted before grant is simply not served. The arbiter holds no per-request state before grant.

## Structure
- **Package `ram`:**
  - `ram_arb_state_e` enum {INIT, RUN}.
  - Default width constants `RAM_DATA_W`=8, `RAM_ADDR_W`=4.
  - Packed struct `ram_arb_tag_t` {valid, id}.
- **Sub-module `ram_rr_pick`:** 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: one-hot `gnt`, `gnt_id`.
  - Purely combinational; the `last` register lives in `ram_arbiter`.
- The tag pipeline and sweep counter live in `ram_arbiter`.

## Test plan
- **Init sweep:** release reset with RAM preloaded with 0xFF. Required:
  - `ram_wr_en` high for 16 consecutive cycles, addresses 0..15, data 0.
  - `init_done_o` rises after the 16th write.
  - `gnt_o` = 0 throughout.
- **Single write then read:** client 0 writes 0xA5 @3, then reads @3. Required:
  - `gnt_o[0]` on each request.
  - `ram_wr_en` one cycle after the first grant.
  - `rvalid_o[0]` with `rdata_o`=0xA5 exactly 2 cycles after the read grant.
- **Contention:** both clients hold read requests (@1 for client 0, @2 for client 1) for 6 cycles. Required:
  - Grants alternate 0,1,0,1,0,1.
  - `rvalid_o` alternates in the same order, 2 cycles later.
- **Back-to-back hazard:** client 1 writes 0x3C @7, then immediately reads @7 in the next cycle. Required: returns 0x3C.
- **Starvation:** client 0 requests continuously while client 1 issues one request. Required: client 1 is granted within 2 cycles.
- **Reset mid-read:** assert `rstn`=0 one cycle after a read grant. Required:
  - No `rvalid_o`.
  - After release, a fresh 16-cycle sweep runs and `init_done_o` is 0 until it ends.
